registro_desp_prog: RTL
=======================

// Module: registro_desp_prog
// PURPOSE
//  Programmable universal shift register: multi-bit PUSH/CYCLE by a runtime amount, parallel LOAD,
//  plus a counted BURST mode that serially shifts LEN bits autonomously.
//  BUSY/DONE handshake for burst completion. Successor to the single-step conditional register;
//  used as the serializer/rotator stage in the proyecto-01 datapath.
// PARAMETERS
//  WIDTH  8  register width Q; >= 2
//  SH_W   3  width of AMT; constraint 2**SH_W-1 <= WIDTH-1
//  CNT_W  4  width of LEN (burst length, 0..2**CNT_W-1)
// PORTS
//  CLK    in   1          clock, rising edge
//  RST    in   1          asynchronous, active-high reset
//  ENB    in   1          clock enable; low freezes all state (Q, S_OUT, FSM, counter)
//  MODO   in   2          `PUSH, `CYCLE, `LOAD, `BURST (definitions.v)
//  DIR    in   1          0 = toward MSB (left), 1 = toward LSB (right)
//  AMT    in   SH_W       shift amount for PUSH/CYCLE
//  LEN    in   CNT_W      burst length, sampled on burst accept
//  D      in   WIDTH      parallel load data
//  S_IN   in   WIDTH      serial-in bits; PUSH uses S_IN[AMT-1:0], BURST uses S_IN[0]
//  Q      out  WIDTH      register contents (registered)
//  S_OUT  out  WIDTH      ejected bits (registered); unused upper bits 0
//  BUSY   out  1          high while FSM in BURST
//  DONE   out  1          one enabled cycle high after burst end
// BEHAVIOUR
//  Reset (async, RST=1): Q=0, S_OUT=0, BUSY=0, DONE=0, FSM=IDLE, counter=0; overrides everything.
//  All updates on posedge CLK only when ENB=1; ENB=0 holds every register, FSM included.
//  FSM states IDLE, BURST, DONE; BUSY=(state==BURST), DONE=(state==DONE), both registered.
//  IDLE, ENB=1, by MODO:
//   `LOAD: Q<=D; S_OUT<=0.
//   `PUSH DIR=0: Q<=(Q<<AMT)|S_IN[AMT-1:0]; S_OUT[AMT-1:0]<=Q[WIDTH-1 -: AMT], rest 0.
//   `PUSH DIR=1: Q<=(Q>>AMT)|(S_IN[AMT-1:0]<<(WIDTH-AMT)); S_OUT[AMT-1:0]<=Q[AMT-1:0].
//   `CYCLE: rotate Q by AMT in DIR; S_OUT<=0.
//   AMT=0 in PUSH/CYCLE: Q holds, S_OUT<=0.
//   `BURST: accept edge: cnt<=LEN, latch DIR into dir_r, no shift, S_OUT<=0;
//     LEN!=0 -> BURST, LEN=0 -> DONE.
//  BURST, ENB=1: shift Q by 1 in dir_r, fill bit = S_IN[0]; S_OUT<=ejected bit in bit 0;
//   cnt<=cnt-1; at cnt==1 next state DONE. MODO/AMT/LEN/D/DIR ignored while BUSY.
//  DONE, ENB=1: Q holds, S_OUT<=0, -> IDLE; new MODO not accepted in this cycle.
//  Burst timing: accept at edge k; shifts on enabled edges k+1..k+LEN; DONE high after
//   edge k+LEN for one enabled cycle; BUSY high exactly LEN enabled cycles.
//  RST mid-burst: aborts, Q=0, no DONE pulse.
//  Shift arithmetic stays in WIDTH bits; no carry/overflow outputs.
// STRUCTURE
//  definitions.v gains `BURST (the remaining 2-bit MODO code) and FSM state macros
//   `RD_IDLE/`RD_BURST/`RD_DONE; `PUSH/`CYCLE/`LOAD keep their current codes.
//  One sub-module: barrel_shift (combinational WIDTH-bit shift/rotate by AMT, DIR, fill input),
//   shared by PUSH, CYCLE and BURST (AMT forced to 1). FSM + counter live in the top.
// TESTING (WIDTH=8, SH_W=3, CNT_W=4)
//  1 RST pulse, then LOAD D=8'hA5 -> Q=8'hA5, S_OUT=0, BUSY=0, DONE=0.
//  2 Q=A5, PUSH DIR=0 AMT=3 S_IN=3'b011 -> Q=8'h2B, S_OUT=8'h05.
//  3 Q=2B, CYCLE DIR=1 AMT=4 -> Q=8'hB2, S_OUT=0; AMT=0 -> Q holds.
//  4 Q=B2, BURST LEN=3 DIR=1 S_IN[0]=1 -> Q D9,EC,F6; S_OUT[0] 0,1,0;
//    BUSY 3 cycles, then DONE 1 cycle.
//  5 Repeat 4 with ENB=0 for 2 cycles after the first shift -> Q/cnt/BUSY frozen;
//    same final Q=F6, DONE once.
//  6 RST asserted mid-burst between edges -> Q=0, BUSY=0 immediately, no DONE;
//    BURST LEN=0 -> DONE next cycle, Q unchanged.

Source files
------------

// File: rtl/registro_desp_prog_pkg.sv
// Shared mode codes, FSM state codes and types for the programmable shift register.
package registro_desp_prog_pkg;

  typedef logic [1:0] modo_t;
  typedef logic [1:0] rd_state_t;

  localparam modo_t MODO_PUSH  = 2'b00;
  localparam modo_t MODO_CYCLE = 2'b01;
  localparam modo_t MODO_LOAD  = 2'b10;
  localparam modo_t MODO_BURST = 2'b11;

  localparam rd_state_t RD_IDLE  = 2'b00;
  localparam rd_state_t RD_BURST = 2'b01;
  localparam rd_state_t RD_DONE  = 2'b10;

endpackage

// File: rtl/registro_desp_prog_barrel_shift.sv
// Combinational WIDTH-bit shift/rotate by a runtime amount; also returns the bits pushed out,
// right-aligned at bit 0.
module barrel_shift #(
  parameter int WIDTH = 8,
  parameter int SH_W  = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SH_W-1:0]  amt_i,
  input  logic             dir_i,
  input  logic             rot_i,
  input  logic [WIDTH-1:0] fill_i,
  output logic [WIDTH-1:0] res_o,
  output logic [WIDTH-1:0] ej_o
);

  localparam int AW = $clog2(WIDTH + 1);

  logic [AW-1:0]    amt_w;
  logic [AW-1:0]    inv_w;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] fill_m;
  logic [WIDTH-1:0] wrap;

  assign amt_w  = AW'(amt_i);
  assign inv_w  = AW'(WIDTH) - amt_w;
  assign mask   = ~({WIDTH{1'b1}} << amt_w);
  assign fill_m = fill_i & mask;

  // With amt=0 the complementary shift is by WIDTH, which yields 0, so nothing wraps or ejects.
  always_comb begin
    wrap  = '0;
    res_o = data_i;
    ej_o  = '0;
    if (!dir_i) begin
      wrap  = rot_i ? (data_i >> inv_w) : fill_m;
      res_o = (data_i << amt_w) | wrap;
      ej_o  = data_i >> inv_w;
    end else begin
      wrap  = rot_i ? (data_i << inv_w) : (fill_m << inv_w);
      res_o = (data_i >> amt_w) | wrap;
      ej_o  = data_i & mask;
    end
  end

endmodule

// File: rtl/registro_desp_prog.sv
// Programmable universal shift register: PUSH/CYCLE by AMT, parallel LOAD, and a counted
// serial BURST with BUSY/DONE handshake.
//
// state    | meaning
// RD_IDLE  | accepts MODO each enabled cycle
// RD_BURST | shifting one bit per enabled cycle, cnt_q bits remain
// RD_DONE  | one-cycle completion pulse, MODO ignored
module registro_desp_prog
  import registro_desp_prog_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH_W  = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enb_i,
  input  modo_t            modo_i,
  input  logic             dir_i,
  input  logic [SH_W-1:0]  amt_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] s_in_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] s_out_o,
  output logic             busy_o,
  output logic             done_o
);

  rd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] s_out_q, s_out_d;

  logic             in_burst;
  logic [SH_W-1:0]  bs_amt;
  logic             bs_dir;
  logic             bs_rot;
  logic [WIDTH-1:0] bs_fill;
  logic [WIDTH-1:0] bs_res;
  logic [WIDTH-1:0] bs_ej;

  // During a burst the shifter is reused as a 1-bit shift in the latched direction.
  assign in_burst = (state_q == RD_BURST);
  assign bs_amt   = in_burst ? SH_W'(1) : amt_i;
  assign bs_dir   = in_burst ? dir_q : dir_i;
  assign bs_rot   = !in_burst && (modo_i == MODO_CYCLE);
  assign bs_fill  = in_burst ? {{(WIDTH-1){1'b0}}, s_in_i[0]} : s_in_i;

  barrel_shift #(
    .WIDTH (WIDTH),
    .SH_W  (SH_W)
  ) u_barrel_shift (
    .data_i (q_q),
    .amt_i  (bs_amt),
    .dir_i  (bs_dir),
    .rot_i  (bs_rot),
    .fill_i (bs_fill),
    .res_o  (bs_res),
    .ej_o   (bs_ej)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    q_d     = q_q;
    s_out_d = '0;
    case (state_q)
      RD_IDLE: begin
        case (modo_i)
          MODO_LOAD:  q_d = d_i;
          MODO_PUSH: begin
            q_d     = bs_res;
            s_out_d = bs_ej;
          end
          MODO_CYCLE: q_d = bs_res;
          MODO_BURST: begin
            cnt_d   = len_i;
            dir_d   = dir_i;
            state_d = (len_i != '0) ? RD_BURST : RD_DONE;
          end
          default: q_d = q_q;
        endcase
      end
      RD_BURST: begin
        q_d     = bs_res;
        s_out_d = bs_ej;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RD_DONE;
      end
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      q_q     <= '0;
      s_out_q <= '0;
    end else if (enb_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
      s_out_q <= s_out_d;
    end
  end

  assign q_o     = q_q;
  assign s_out_o = s_out_q;
  assign busy_o  = (state_q == RD_BURST);
  assign done_o  = (state_q == RD_DONE);

endmodule
